// File: rtl/pipe_reg_skid.sv
// Handshaked pipeline-stage register with a two-entry skid buffer, flush-to-bubble
// and saturating stall/flush counters. in_ready comes straight from a flop.
module pipe_reg_skid #(
  parameter int CTRL_WIDTH = 12,
  parameter int DATA_WIDTH = 185,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  flush,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state;
  logic   main_valid, skid_valid;
  beat_t  main_q, skid_q, in_beat;
  logic   in_xfer, out_xfer;

  assign in_beat   = '{ctrl: in_ctrl, data: in_data};
  assign in_ready  = !skid_valid;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_q.ctrl : '0;
  assign out_data  = main_q.data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Bubble: drop everything, zero control, keep data so the datapath doesn't toggle.
      state       <= EMPTY;
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_q.ctrl <= '0;
      skid_q.ctrl <= '0;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          main_q     <= in_beat;
          main_valid <= 1'b1;
          state      <= BUSY;
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_beat;
          end else if (in_xfer) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
            state      <= FULL;
          end else if (out_xfer) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        FULL: if (out_xfer) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
          state      <= BUSY;
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (main_valid || skid_valid) && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_reg_skid.md
# pipe_reg_skid

Parametrised, handshaked pipeline-stage register that replaces fixed stage registers between CPU pipeline stages. Carries a control payload and a data payload through a two-entry skid buffer with valid/ready flow control, synchronous flush (bubble insertion) and saturating stall/flush performance counters. Defaults size it as the Decode→Execute boundary. Placed between stages so that back-pressure from a later stage never needs a combinational path back to the earlier stage.

## Interface
Parameters:
- CTRL_WIDTH, 12, control payload bits (RegWrite, ResultSrc, MemWrite, MemRead, Jump, Branch, ALUControl, ALUSrc); forced to zero on bubbles
- DATA_WIDTH, 185, data payload bits (operands, PC, PC+4, immediate, register addresses, funct3, opcode); never forced
- CNT_WIDTH, 16, width of each performance counter

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_ctrl  in  CTRL_WIDTH  upstream control payload
- in_data  in  DATA_WIDTH  upstream data payload
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_WIDTH  control payload; all-zero whenever out_valid=0
- out_data  out  DATA_WIDTH  data payload; holds last loaded value when out_valid=0
- flush  in  1  synchronous flush; discards all held and incoming beats
- cnt_clr  in  1  synchronous clear of both counters
- stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_WIDTH  cycles with flush=1 and at least one entry valid, saturating

## Operation
- Storage: main entry (drives outputs) and skid entry; each has valid, ctrl, data.
- States: EMPTY (no entry valid), BUSY (main only), FULL (main and skid).
- in_ready = !skid_valid, driven directly from a register, no combinational path from out_ready. in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- out_valid = main_valid; out_ctrl = main_valid ? main_ctrl : 0; out_data = main_data.
- Transitions (flush=0):
  - EMPTY: in_xfer → main ← in, BUSY; else stay.
  - BUSY: in_xfer & out_xfer → main ← in, BUSY; in_xfer & !out_ready → skid ← in, FULL; !in_xfer & out_xfer → EMPTY; else hold.
  - FULL: out_xfer → main ← skid, skid invalid, BUSY; else hold. No in_xfer possible (in_ready=0).
- Flush (priority over all transitions): both valids cleared, main_ctrl and skid_ctrl zeroed, data registers held, incoming beat discarded even if in_valid=1 and in_ready=1; next state EMPTY. A downstream transfer in the flush cycle still completes (out_ready sampled normally).
- Counters: stall_cnt +1 per cycle out_valid & !out_ready; flush_cnt +1 per cycle flush & (main_valid | skid_valid). Both stop at 2^CNT_WIDTH−1. cnt_clr zeroes both and overrides increment in that cycle.
- Ordering: beats leave in acceptance order; no beat is duplicated or dropped except by flush.

## Timing
- Reset (RST_N=0, immediate): state EMPTY, all valids 0, all ctrl/data registers 0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, flush_cnt=0. Reset mid-transfer discards all entries.
- Latency: beat accepted at edge N appears on out_* after edge N (visible in cycle N+1) when EMPTY or BUSY-with-drain.
- Throughput: one beat per cycle with out_ready held at 1; in_ready stays 1.
- Back-pressure: in_ready falls the cycle after out_ready=0 causes a skid load; one extra beat absorbed, none lost.
- in_ready returns to 1 the cycle after FULL drains to BUSY.
- flush=1 at edge N: out_valid=0 and out_ctrl=0 from edge N; in_ready=1 from edge N.

## Test plan
- Reset: RST_N low mid-stream with FULL → out_valid=0, out_ctrl=0, in_ready=1, counters 0 immediately without a clock edge.
- Streaming: out_ready=1, send beats ctrl=0x001..0x00A, data=1..10 back-to-back → each appears one cycle later in order, in_ready never falls, stall_cnt=0.
- Skid: stream beats A,B,C; drop out_ready for 3 cycles after A appears → B held in skid, in_ready=0, C waits upstream; stall_cnt=3; on release output order A,B,C, none lost.
- Flush in FULL: hold FULL, assert flush with in_valid=1 (beat X) → next cycle out_valid=0, out_ctrl=0x000, out_data unchanged, X never appears, flush_cnt=1; flush again while EMPTY → flush_cnt stays 1.
- Saturation: CNT_WIDTH=4, out_ready=0 with valid entry for 20 cycles → stall_cnt=15; cnt_clr with stall continuing → 0 that cycle, 1 next.
- Flush with simultaneous drain: BUSY, out_ready=1, flush=1 → beat counted as transferred by downstream monitor, state EMPTY, no duplicate output.
